// File: rtl/uart_bus_master_pkg.sv
// Shared command/response codes and frame FSM state encoding for the UART bus bridge.
package uart_bus_master_pkg;

    localparam logic [7:0] CMD_WR  = 8'hA5;
    localparam logic [7:0] CMD_RD  = 8'h5A;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_ADDR   = 6'b000010,
        S_DATA   = 6'b000100,
        S_REQ    = 6'b001000,
        S_ACCESS = 6'b010000,
        S_RESP   = 6'b100000
    } state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter: accepts a byte when idle, shifts start, 8 data bits LSB first, stop.
module uart_byte_tx #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx
);

    localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

    logic [8:0]  r_shift;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_baud_cnt;
    logic        r_busy;
    logic        r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '1;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_busy     <= 1'b0;
            r_tx       <= 1'b1;
        end else if (!r_busy) begin
            if (i_valid) begin
                r_busy     <= 1'b1;
                r_tx       <= 1'b0;
                r_shift    <= {1'b1, i_data};
                r_bit_cnt  <= 4'd9;
                r_baud_cnt <= BAUD_MAX;
            end
        end else if (r_baud_cnt != 16'd0) begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
        end else if (r_bit_cnt == 4'd0) begin
            // Stop bit has been on the line for a full bit period.
            r_busy <= 1'b0;
        end else begin
            r_tx       <= r_shift[0];
            r_shift    <= {1'b1, r_shift[8:1]};
            r_bit_cnt  <= r_bit_cnt - 4'd1;
            r_baud_cnt <= BAUD_MAX;
        end
    end

    assign o_ready = !r_busy;
    assign o_tx    = r_tx;

endmodule

// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: receives write/read command frames, performs one bus access, replies.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 434,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic        req_o,
    input  logic        gnt_i,
    output logic        wr_en_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    output logic        busy_o
);

    localparam logic [15:0] BAUD_MAX   = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_MAX   = 16'(CLK_DIV / 2 - 1);
    localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * CLK_DIV;
    localparam int unsigned TMO_W      = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    // Receiver
    logic        r_rx_s1, r_rx_s2, r_rx_s3;
    logic        r_rx_active;
    logic [15:0] r_rx_cnt;
    logic [3:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        w_start_edge, w_rx_tick, w_rx_done, w_rx_ferr;

    assign w_start_edge = !r_rx_active && r_rx_s3 && !r_rx_s2;
    assign w_rx_tick    = r_rx_active && (r_rx_cnt == 16'd0);
    assign w_rx_done    = w_rx_tick && (r_rx_bit == 4'd9) && r_rx_s2;
    assign w_rx_ferr    = w_rx_tick && (r_rx_bit == 4'd9) && !r_rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_s3     <= 1'b1;
            r_rx_active <= 1'b0;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
        end else begin
            r_rx_s1 <= rx_pin;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
            if (w_start_edge) begin
                r_rx_active <= 1'b1;
                r_rx_cnt    <= HALF_MAX;
                r_rx_bit    <= 4'd0;
            end else if (r_rx_active) begin
                if (r_rx_cnt != 16'd0) begin
                    r_rx_cnt <= r_rx_cnt - 16'd1;
                end else begin
                    r_rx_cnt <= BAUD_MAX;
                    // Line back high at start-bit centre means a glitch, not a byte.
                    if ((r_rx_bit == 4'd0 && r_rx_s2) || r_rx_bit == 4'd9) begin
                        r_rx_active <= 1'b0;
                    end else begin
                        if (r_rx_bit != 4'd0) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bit <= r_rx_bit + 4'd1;
                    end
                end
            end
        end
    end

    // Frame FSM
    state_e           r_state;
    logic [1:0]       r_byte_cnt;
    logic             r_is_wr;
    logic [31:0]      r_addr_sh, r_data_sh;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_req, r_wr_en;
    logic [31:0]      r_addr, r_data;
    logic [31:0]      r_rd_data;
    logic [1:0]       r_resp_left;
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;
    logic             w_tx_ready;
    logic [31:0]      w_addr_next, w_data_next;

    assign w_addr_next = {r_rx_shift, r_addr_sh[31:8]};
    assign w_data_next = {r_rx_shift, r_data_sh[31:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= '0;
            r_is_wr     <= 1'b0;
            r_addr_sh   <= '0;
            r_data_sh   <= '0;
            r_tmo_cnt   <= '0;
            r_req       <= 1'b0;
            r_wr_en     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rd_data   <= '0;
            r_resp_left <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            if (r_tx_valid && w_tx_ready) r_tx_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_rx_done) begin
                        r_byte_cnt <= '0;
                        r_tmo_cnt  <= '0;
                        if (r_rx_shift == CMD_WR || r_rx_shift == CMD_RD) begin
                            r_is_wr <= (r_rx_shift == CMD_WR);
                            r_state <= S_ADDR;
                        end else begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= RSP_NAK;
                        end
                    end
                end
                S_ADDR, S_DATA: begin
                    // A completed byte takes priority over a coincident timeout.
                    if (w_rx_done) begin
                        r_tmo_cnt  <= '0;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_state == S_ADDR) r_addr_sh <= w_addr_next;
                        else                   r_data_sh <= w_data_next;
                        if (r_byte_cnt == 2'd3) begin
                            if (r_state == S_ADDR && r_is_wr) begin
                                r_state <= S_DATA;
                            end else begin
                                r_state <= S_REQ;
                                r_req   <= 1'b1;
                                if (r_state == S_ADDR) begin
                                    r_addr <= w_addr_next;
                                end else begin
                                    r_addr <= r_addr_sh;
                                    r_data <= w_data_next;
                                end
                            end
                        end
                    end else if (w_rx_ferr || r_tmo_cnt == TMO_LAST) begin
                        r_state <= S_IDLE;
                    end else if (w_start_edge) begin
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_REQ: begin
                    if (gnt_i) begin
                        r_state <= S_ACCESS;
                        r_wr_en <= r_is_wr;
                    end
                end
                S_ACCESS: begin
                    r_req       <= 1'b0;
                    r_wr_en     <= 1'b0;
                    r_rd_data   <= {8'h00, data_i[31:8]};
                    r_tx_valid  <= 1'b1;
                    r_tx_data   <= r_is_wr ? RSP_ACK : data_i[7:0];
                    r_resp_left <= r_is_wr ? 2'd0 : 2'd3;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (r_tx_valid && w_tx_ready) begin
                        if (r_resp_left == 2'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_tx_valid  <= 1'b1;
                            r_tx_data   <= r_rd_data[7:0];
                            r_rd_data   <= {8'h00, r_rd_data[31:8]};
                            r_resp_left <= r_resp_left - 2'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    uart_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (r_tx_data),
        .i_valid (r_tx_valid),
        .o_ready (w_tx_ready),
        .o_tx    (tx_pin)
    );

    assign req_o   = r_req;
    assign wr_en_o = r_wr_en;
    assign addr_o  = r_addr;
    assign data_o  = r_data;
    assign busy_o  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Randomised scoreboard bench for uart_bus_master: serial host driver, bus responder, monitors.
module tb_uart_bus_master;

    localparam int unsigned CLK_DIV      = 16;
    localparam int unsigned TIMEOUT_BITS = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_pin = 1'b1;
    logic        tx_pin;
    logic        req_o;
    logic        gnt_i = 1'b0;
    logic        wr_en_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i = '0;
    logic        busy_o;

    always #5 clk = ~clk;

    uart_bus_master #(
        .CLK_DIV      (CLK_DIV),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_pin  (rx_pin),
        .tx_pin  (tx_pin),
        .req_o   (req_o),
        .gnt_i   (gnt_i),
        .wr_en_o (wr_en_o),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .data_i  (data_i),
        .busy_o  (busy_o)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          gnt_delay = 0;
    bit          tx_abort = 1'b0;
    acc_t        exp_acc[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] resp_mem[logic [31:0]];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Contents of a responder location nobody has written.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C96_A55A;
    endfunction

    // Reference model: what a host frame must cause on the bus and on the reply line.
    task automatic model_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        if (cmd == 8'hA5) begin
            exp_acc.push_back('{is_wr: 1'b1, addr: a, data: d});
            model_mem[a] = d;
            exp_tx.push_back(8'h06);
        end else if (cmd == 8'h5A) begin
            v = model_mem.exists(a) ? model_mem[a] : dflt(a);
            exp_acc.push_back('{is_wr: 1'b0, addr: a, data: 32'h0});
            for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
        end else begin
            exp_tx.push_back(8'h15);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_pin = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx_pin = stop;
        repeat (CLK_DIV) @(negedge clk);
        rx_pin = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
        model_frame(cmd, a, d);
        send_byte(cmd, 1'b1);
        if (cmd == 8'hA5 || cmd == 8'h5A) begin
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, CLK_DIV)) @(negedge clk);
                send_byte(a[8*i +: 8], 1'b1);
            end
        end
        if (cmd == 8'hA5) begin
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, CLK_DIV)) @(negedge clk);
                send_byte(d[8*i +: 8], 1'b1);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int cnt = 0;
        while ((exp_tx.size() != 0 || busy_o) && cnt < 4000) begin
            @(negedge clk);
            cnt++;
        end
        check($sformatf("%s_done", tag), 32'(cnt < 4000), 32'd1);
        check($sformatf("%s_pending_access", tag), 32'(exp_acc.size()), 32'd0);
        exp_tx.delete();
        exp_acc.delete();
        repeat (CLK_DIV) @(negedge clk);
    endtask

    // Arbiter: grants gnt_delay cycles after seeing a request, releases with req_o.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && req_o && !gnt_i) begin
                repeat (gnt_delay) @(posedge clk);
                @(posedge clk);
                #1 gnt_i = 1'b1;
            end else if (!req_o) begin
                gnt_i = 1'b0;
            end
        end
    end

    // Bus monitor and responder.
    initial begin
        logic        p_req = 1'b0;
        logic        p_wr = 1'b0;
        logic [31:0] p_addr = '0;
        logic [31:0] p_data = '0;
        int          req_hi = 0;
        int          wr_pulses = 0;
        acc_t        a;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_req = 1'b0;
            end else begin
                if (p_req && !req_o) begin
                    check("wr_en_after_release", 32'(wr_en_o), 32'd0);
                    if (exp_acc.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL bus_access: got access at %h expected none", p_addr);
                    end else begin
                        a = exp_acc.pop_front();
                        check("access_kind", 32'(p_wr), 32'(a.is_wr));
                        check("addr_o", p_addr, a.addr);
                        if (a.is_wr) check("data_o", p_data, a.data);
                        check("wr_en_pulses", 32'(wr_pulses), 32'(a.is_wr));
                        check("req_high_cycles", 32'(req_hi), 32'(gnt_delay + 3));
                    end
                end
                if (!p_req && req_o) begin
                    req_hi = 0;
                    wr_pulses = 0;
                end
                if (req_o) req_hi++;
                if (wr_en_o) wr_pulses++;
                if (wr_en_o && req_o) resp_mem[addr_o] = data_o;
                data_i = resp_mem.exists(addr_o) ? resp_mem[addr_o] : dflt(addr_o);
                p_req  = req_o;
                p_wr   = wr_en_o;
                p_addr = addr_o;
                p_data = data_o;
            end
        end
    end

    // Serial reply monitor.
    initial begin
        logic [7:0] b;
        logic       stop;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && tx_pin == 1'b0) begin
                repeat (CLK_DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = tx_pin;
                end
                repeat (CLK_DIV) @(negedge clk);
                stop = tx_pin;
                if (tx_abort) begin
                    tx_abort = 1'b0;
                end else if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_byte: got %h expected none", b);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_byte", 32'(b), 32'(e));
                    check("tx_stop_bit", 32'(stop), 32'd1);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cmd;
        logic [31:0] a;
        int          k;
        resp_mem[32'h20]  = 32'h1234_5678;
        model_mem[32'h20] = 32'h1234_5678;

        repeat (5) @(posedge clk);
        #1;
        check("rst_tx_pin", 32'(tx_pin), 32'd1);
        check("rst_req_o", 32'(req_o), 32'd0);
        check("rst_wr_en_o", 32'(wr_en_o), 32'd0);
        check("rst_addr_o", addr_o, 32'd0);
        check("rst_data_o", data_o, 32'd0);
        check("rst_busy_o", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_frame(8'hA5, 32'h0000_0010, 32'hDEAD_BEEF);
        wait_idle("write");
        run_frame(8'h5A, 32'h0000_0020, 32'h0);
        wait_idle("read");

        gnt_delay = 50;
        run_frame(8'hA5, 32'h0000_0030, 32'hCAFE_F00D);
        wait_idle("grant_delay");
        gnt_delay = 0;

        run_frame(8'h33, 32'h0, 32'h0);
        wait_idle("bad_cmd");

        send_byte(8'h5A, 1'b1);
        send_byte(8'h20, 1'b0);
        repeat (2 * CLK_DIV) @(negedge clk);
        check("framing_error_idle", 32'(busy_o), 32'd0);
        wait_idle("framing_error");

        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        check("timeout_mid_frame_busy", 32'(busy_o), 32'd1);
        repeat (21 * CLK_DIV) @(negedge clk);
        check("timeout_idle", 32'(busy_o), 32'd0);
        run_frame(8'hA5, 32'h1000_0004, $urandom);
        wait_idle("after_timeout");

        rx_pin = 1'b0;
        repeat (CLK_DIV / 4) @(negedge clk);
        rx_pin = 1'b1;
        repeat (12 * CLK_DIV) @(negedge clk);
        check("glitch_idle", 32'(busy_o), 32'd0);
        wait_idle("glitch");

        for (int n = 0; n < 14; n++) begin
            k = $urandom_range(0, 9);
            a = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 2);
            if (k < 5)      cmd = 8'hA5;
            else if (k < 9) cmd = 8'h5A;
            else begin
                cmd = 8'($urandom);
                if (cmd == 8'hA5 || cmd == 8'h5A) cmd = 8'h33;
            end
            gnt_delay = $urandom_range(0, 6);
            run_frame(cmd, a, $urandom);
            wait_idle($sformatf("random%0d", n));
        end

        gnt_delay = 0;
        run_frame(8'h5A, 32'h1000_0008, 32'h0);
        k = 0;
        while (tx_pin && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("reply_started", 32'(k < 3000), 32'd1);
        repeat (3 * CLK_DIV) @(negedge clk);
        tx_abort = 1'b1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_tx_tx_pin", 32'(tx_pin), 32'd1);
        check("reset_mid_tx_busy", 32'(busy_o), 32'd0);
        check("reset_mid_tx_req", 32'(req_o), 32'd0);
        exp_tx.delete();
        exp_acc.delete();
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * CLK_DIV) @(negedge clk);
        run_frame(8'hA5, 32'h1000_001C, 32'h0BAD_F00D);
        wait_idle("post_reset_write");
        run_frame(8'h5A, 32'h1000_001C, 32'h0);
        wait_idle("post_reset_read");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
